// File: rtl/atan_pkg.sv
// Shared binary32 field widths, constants and FSM state type for the atan
// argument-range-reduction stage and its reciprocal mantissa divider.
package atan_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIG_W    = FRAC_W + 1;
    localparam int FP_W     = 1 + EXP_W + FRAC_W;
    localparam int BIAS     = 127;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    // 24 significand bits, one guard bit, and one extra bit folded into sticky.
    localparam int DIV_ITER = 26;
    localparam int ITER_W   = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/recip_mant_div.sv
// Iterative restoring divider computing 2^49 / {1,f}: one quotient bit per
// cycle for DIV_ITER cycles, reporting the 24-bit quotient, guard and sticky.
module recip_mant_div
    import atan_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SIG_W-1:0] mant,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] quotient,
    output logic             guard,
    output logic             sticky
);

    logic [SIG_W-1:0]    divisor;
    logic [SIG_W-1:0]    rem;
    logic [DIV_ITER-1:0] quo;
    logic [ITER_W-1:0]   iter;
    logic [SIG_W:0]      rem_shift;
    logic                take;
    logic [SIG_W-1:0]    rem_next;

    // NOTE: every signal gets a default before any conditional update, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        rem_shift = {rem, 1'b0};
        take      = (rem_shift >= {1'b0, divisor});
        rem_next  = rem_shift[SIG_W-1:0];
        if (take) begin
            rem_next = SIG_W'(rem_shift - {1'b0, divisor});
        end
    end

    // High during the cycle whose closing edge retires the final iteration.
    assign done = busy && (iter == ITER_W'(DIV_ITER - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            iter <= '0;
        end else if (start) begin
            busy <= 1'b1;
            iter <= '0;
        end else if (busy) begin
            iter <= iter + ITER_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    // NOTE: the datapath registers carry no reset; they are always loaded by
    // start before being read, so only the control bits above need one.
    always_ff @(posedge clock) begin
        if (start) begin
            divisor <= mant;
            rem     <= {1'b1, {FRAC_W{1'b0}}};
            quo     <= '0;
        end else if (busy) begin
            rem     <= rem_next;
            quo     <= {quo[DIV_ITER-2:0], take};
        end
    end

    assign quotient = quo[DIV_ITER-1 -: SIG_W];
    assign guard    = quo[DIV_ITER-SIG_W-1];
    assign sticky   = quo[0] | (rem != '0);

endmodule

// File: rtl/atan_range_reduce.sv
// Range reduction ahead of atan: forwards 1/y with invert=1 when |y| > 1.
// Build option ATAN_REDUCE_SUBNORM_EN: round tiny reciprocals as subnormals.
module atan_range_reduce
    import atan_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [FP_W-1:0] io_in_bits,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [FP_W-1:0] io_out_bits,
    output logic            io_out_invert
);

    state_t           state;
    fp32_t            in_fp;
    logic             is_nan;
    logic             is_inf;
    logic             is_small;
    logic             accept;
    logic             div_start;

    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic             frac_zero_q;

    logic             div_busy;
    logic             div_done;
    logic [SIG_W-1:0] div_quo;
    logic             div_guard;
    logic             div_sticky;

    assign in_fp    = fp32_t'(io_in_bits);
    assign is_nan   = (&in_fp.exp) && (|in_fp.frac);
    assign is_inf   = (&in_fp.exp) && !(|in_fp.frac);
    assign is_small = (in_fp.exp < EXP_W'(BIAS)) ||
                      ((in_fp.exp == EXP_W'(BIAS)) && (in_fp.frac == '0));

    assign io_in_ready  = (state == ST_IDLE) && !div_busy;
    assign io_out_valid = (state == ST_DONE);
    assign accept       = io_in_valid && io_in_ready;
    assign div_start    = accept && !is_nan && !is_inf && !is_small;

    recip_mant_div u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .mant     ({1'b1, in_fp.frac}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .guard    (div_guard),
        .sticky   (div_sticky)
    );

    logic signed [EXP_W+1:0] res_exp;
    logic [SIG_W-1:0]        sig;
    logic                    grd;
    logic                    stk;
    logic                    round_up;
    logic [SIG_W:0]          sum;
    logic signed [EXP_W+1:0] norm_exp;
    logic [FRAC_W-1:0]       norm_mant;
    logic [FP_W-1:0]         norm_bits;
    logic [FP_W-1:0]         tiny_bits;
    logic [FP_W-1:0]         round_bits;
`ifdef ATAN_REDUCE_SUBNORM_EN
    logic [1:0]              sub_shift;
    logic [SIG_W+2:0]        ext_sh;
    logic [SIG_W-1:0]        sub_sig;
    logic                    sub_up;
`endif

    always_comb begin
        // A power of two divides exactly: its reciprocal is 1.0 * 2^(254-e).
        res_exp = (frac_zero_q ? 10'sd254 : 10'sd253) - $signed({2'b00, exp_q});
        sig     = frac_zero_q ? {1'b1, {FRAC_W{1'b0}}} : div_quo;
        grd     = !frac_zero_q && div_guard;
        stk     = !frac_zero_q && div_sticky;

        round_up  = grd && (stk || sig[0]);
        sum       = {1'b0, sig} + (SIG_W+1)'(round_up);
        norm_exp  = res_exp + $signed({{(EXP_W+1){1'b0}}, sum[SIG_W]});
        norm_mant = sum[SIG_W] ? sum[SIG_W-1:1] : sum[FRAC_W-1:0];
        norm_bits = {sign_q, EXP_W'(norm_exp), norm_mant};

`ifdef ATAN_REDUCE_SUBNORM_EN
        // Smallest reachable exponent is -1 (y just below 2^128), so shift by 1 or 2.
        sub_shift = (res_exp == 10'sd0) ? 2'd1 : 2'd2;
        ext_sh    = {sig, grd, 2'b00} >> sub_shift;
        sub_sig   = ext_sh[SIG_W+2:3];
        sub_up    = ext_sh[2] && (stk || ext_sh[1] || ext_sh[0] || sub_sig[0]);
        // A carry into bit 23 lands in the exponent field as the smallest normal.
        tiny_bits = {sign_q, {(EXP_W-1){1'b0}}, sub_sig + SIG_W'(sub_up)};
`else
        tiny_bits = {sign_q, {(FP_W-1){1'b0}}};
`endif
        round_bits = (res_exp <= 10'sd0) ? tiny_bits : norm_bits;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            io_out_bits   <= '0;
            io_out_invert <= 1'b0;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            frac_zero_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sign_q      <= in_fp.sign;
                        exp_q       <= in_fp.exp;
                        frac_zero_q <= (in_fp.frac == '0);
                        if (is_nan) begin
                            io_out_bits   <= QNAN;
                            io_out_invert <= 1'b0;
                            state         <= ST_DONE;
                        end else if (is_inf) begin
                            io_out_bits   <= {in_fp.sign, {(FP_W-1){1'b0}}};
                            io_out_invert <= 1'b1;
                            state         <= ST_DONE;
                        end else if (is_small) begin
                            io_out_bits   <= io_in_bits;
                            io_out_invert <= 1'b0;
                            state         <= ST_DONE;
                        end else begin
                            io_out_invert <= 1'b1;
                            state         <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    io_out_bits <= round_bits;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (io_out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/atan_range_reduce.md
# atan_range_reduce

Argument-range-reduction stage placed directly upstream of `Atan`. It accepts an IEEE-754 binary32 operand over a valid/ready handshake. When |y| > 1.0 it forwards 1/y, computed with an iterative restoring mantissa divider, and raises `io_out_invert` so the downstream fix-up can form sign(y)·π/2 − atan(1/y). Every other operand is forwarded unchanged or as a canonical special value.

## Interface
Parameters:
- none: format is fixed at binary32, and the iteration count lives in the package.

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `io_in_valid`  in  1  operand offered
- `io_in_ready`  out  1  block idle and able to accept
- `io_in_bits`  in  32  binary32 operand y
- `io_out_valid`  out  1  result held
- `io_out_ready`  in  1  consumer accepts result
- `io_out_bits`  out  32  reduced operand (binary32)
- `io_out_invert`  out  1  1 = `io_out_bits` is 1/y and the fix-up must be applied

## Operation
- States: IDLE, DIV, ROUND, DONE.
- `io_in_ready` = (state == IDLE). The block holds one operand at a time and never overlaps operations.
- Classification at accept. Fields: s = sign, e = exponent, f = fraction.
  - NaN → bits 0x7FC00000, invert 0; go to DONE.
  - ±Inf → bits {s, 31'b0}, invert 1; go to DONE.
  - |y| ≤ 1.0 (e < 127, or y == ±1.0, or zero, or subnormal) → bits = y unchanged, invert 0; go to DONE.
  - Otherwise → invert 1; go to DIV.
- DIV iteration:
  - m = {1, f} (24 bits); remainder r starts at 2^23.
  - Each iteration: r ← r << 1; if r ≥ m then r ← r − m and shift in 1, else shift in 0.
  - 26 iterations produce 24 significand bits plus 1 guard bit. Sticky = (r ≠ 0).
- ROUND:
  - Biased result exponent = 253 − e when f ≠ 0, and 254 − e when f == 0 (exact power of two).
  - Round to nearest, ties to even.
  - A rounding carry-out renormalizes the significand and increments the exponent.
  - Result sign = s.
- Subnormal results (biased exponent ≤ 0) are handled as described under Configuration.
- DONE: hold all outputs stable until `io_out_ready`. On the handshake, go to IDLE.

## Timing
- Reset values: state IDLE; `io_in_ready` 1; `io_out_valid` 0; `io_out_bits` 0x00000000; `io_out_invert` 0.
- Accept edge is N, where `io_in_valid` & `io_in_ready` is true.
- Bypass and special-value classes: `io_out_valid` = 1 from edge N+1.
- Divide class: DIV occupies edges N+1 to N+26, ROUND is edge N+27, and `io_out_valid` = 1 from edge N+28. Latency is exactly 28 cycles.
- Output handshake edge is M, where `io_out_valid` & `io_out_ready` is true. `io_in_ready` = 1 from edge M+1, so there is no same-cycle re-accept.
- While `io_out_ready` = 0, `io_out_bits` and `io_out_invert` must not change.
- `io_in_valid` outside IDLE is ignored.
- `reset` asserted in any state aborts the operation and restores the reset values on the next edge. No partial result is emitted.

## Configuration
- `ATAN_REDUCE_SUBNORM_EN` defined:
  - Reciprocals with biased exponent ≤ 0 are shifted right into subnormal form before rounding.
  - Bits shifted out are ORed into sticky.
  - The result is correctly rounded.
- `ATAN_REDUCE_SUBNORM_EN` undefined:
  - Any reciprocal with biased exponent ≤ 0 is flushed to {s, 31'b0}, with invert still 1.
- Latency is identical in both builds.

## Structure
- Shared package `atan_pkg`:
  - binary32 field widths;
  - BIAS = 127;
  - QNAN = 32'h7FC00000;
  - DIV_ITER = 26;
  - state enum.
- Sub-module `recip_mant_div`:
  - iterative restoring 24-bit divider;
  - start/busy/done interface;
  - outputs the quotient, guard and sticky bits.
- Classification, exponent arithmetic, rounding and the handshake FSM remain in `atan_range_reduce`.

## Test plan
- 0x41200000 (10.0) → 0x3DCCCCCD, invert 1, valid exactly 28 cycles after accept; 0xC1A00000 (−20.0) → 0xBD4CCCCD, invert 1.
- 0x3F000000 (0.5) → 0x3F000000, invert 0, 1 cycle; 0x3F800000 (1.0) → 0x3F800000, invert 0; 0x00000000 → 0x00000000, invert 0.
- 0x7F800000 → 0x00000000, invert 1; 0xFF800000 → 0x80000000, invert 1; 0x7FC00001 → 0x7FC00000, invert 0.
- 0x7F000000 (2^127) → 0x00400000 with `ATAN_REDUCE_SUBNORM_EN`, 0x00000000 without; invert 1 in both builds.
- Back-pressure: hold `io_out_ready` low 5 cycles after valid → bits and invert stable and `io_in_ready` 0 throughout; the next operand is accepted the cycle after the handshake.
- Assert `reset` at DIV cycle 10 → outputs at reset values next cycle; a following 0x4E3EBC20 completes normally, matching a reference 1/y rounded to nearest-even binary32.
